// File: rtl/shift_left_logical_seq_32bit_if.sv
// shift_left_logical_seq_32bit_if: start/done handshake, operands and result of the sequential shifter.
// o_ovf exists only when SLL_SEQ_OVERFLOW_EN is defined.
interface shift_left_logical_seq_32bit_if;
    logic        i_start;
    logic [31:0] i_x;
    logic [31:0] i_y;
    logic        o_busy;
    logic        o_done;
    logic [31:0] o_z;
`ifdef SLL_SEQ_OVERFLOW_EN
    logic        o_ovf;
    modport slave  (input i_start, i_x, i_y, output o_busy, o_done, o_z, o_ovf);
    modport master (output i_start, i_x, i_y, input o_busy, o_done, o_z, o_ovf);
`else
    modport slave  (input i_start, i_x, i_y, output o_busy, o_done, o_z);
    modport master (output i_start, i_x, i_y, input o_busy, o_done, o_z);
`endif
endinterface

// File: rtl/shift_left_logical_seq_32bit.sv
// shift_left_logical_seq_32bit: multi-cycle logical left shift, STEP bits per clock, start/done handshake.
// Optional sticky overflow output enabled by SLL_SEQ_OVERFLOW_EN.
module shift_left_logical_seq_32bit #(
    parameter int STEP = 1
) (
    input logic clk,
    input logic rst_n,
    shift_left_logical_seq_32bit_if.slave io_bus
);
    generate
        if (!(STEP == 1 || STEP == 2 || STEP == 4 || STEP == 8 || STEP == 16)) begin : g_bad_step
            $error("STEP must be 1, 2, 4, 8 or 16");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, SHIFT, DONE} state_t;
    localparam logic [4:0] STEP_W = 5'(STEP);

    state_t      r_state, w_state_nxt;
    logic [31:0] r_acc, r_z, w_acc_nxt;
    logic [4:0]  r_cnt, w_cnt_nxt, w_s;
    logic        w_accept, w_oor;

    always_comb begin
        w_accept = io_bus.i_start && (r_state != SHIFT);
        w_oor = io_bus.i_y[31] || (|io_bus.i_y[30:5]);
        w_s = (r_cnt < STEP_W) ? r_cnt : STEP_W;
        w_acc_nxt = r_acc;
        w_cnt_nxt = r_cnt;
        w_state_nxt = IDLE;
        if (w_accept) begin
            w_acc_nxt = w_oor ? '0 : io_bus.i_x;
            w_cnt_nxt = io_bus.i_y[4:0];
            w_state_nxt = (w_oor || io_bus.i_y[4:0] == 5'd0) ? DONE : SHIFT;
        end else if (r_state == SHIFT) begin
            w_acc_nxt = r_acc << w_s;
            w_cnt_nxt = r_cnt - w_s;
            w_state_nxt = (w_cnt_nxt == 5'd0) ? DONE : SHIFT;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
            r_acc <= '0;
            r_cnt <= '0;
            r_z <= '0;
        end else begin
            r_state <= w_state_nxt;
            r_acc <= w_acc_nxt;
            r_cnt <= w_cnt_nxt;
            if (w_state_nxt == DONE) r_z <= w_acc_nxt;
        end
    end

    assign io_bus.o_busy = (r_state == SHIFT);
    assign io_bus.o_done = (r_state == DONE);
    assign io_bus.o_z = r_z;

`ifdef SLL_SEQ_OVERFLOW_EN
    logic r_ovf_run, r_ovf, w_lost, w_ovf_nxt;

    // top w_s bits of acc are the ones pushed past bit 31 this step
    assign w_lost = |(r_acc & ~(32'hFFFF_FFFF >> w_s));

    always_comb begin
        w_ovf_nxt = r_ovf_run;
        if (w_accept) w_ovf_nxt = w_oor && (|io_bus.i_x);
        else if (r_state == SHIFT) w_ovf_nxt = r_ovf_run | w_lost;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ovf_run <= 1'b0;
            r_ovf <= 1'b0;
        end else begin
            r_ovf_run <= w_ovf_nxt;
            r_ovf <= (w_state_nxt == DONE) ? w_ovf_nxt : (w_accept ? 1'b0 : r_ovf);
        end
    end

    assign io_bus.o_ovf = r_ovf;
`endif
endmodule

// File: tb/tb_shift_left_logical_seq_32bit.sv
// tb_shift_left_logical_seq_32bit: drives one instance per legal STEP in lockstep and checks
// result, latency, busy duration and Z stability against a plain-arithmetic reference model.
module tb_shift_left_logical_seq_32bit;
    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [31:0] x_in = '0;
    logic [31:0] y_in = '0;
    logic        busy_v [5];
    logic        done_v [5];
    logic [31:0] z_v [5];
    logic [31:0] prev_z [5];
    int          checks = 0;
    int          failures = 0;
`ifdef SLL_SEQ_OVERFLOW_EN
    logic        ovf_v [5];
`endif

    always #5 clk = ~clk;

    for (genvar k = 0; k < 5; k++) begin : g_dut
        shift_left_logical_seq_32bit_if bus ();
        assign bus.i_start = start;
        assign bus.i_x = x_in;
        assign bus.i_y = y_in;
        assign busy_v[k] = bus.o_busy;
        assign done_v[k] = bus.o_done;
        assign z_v[k] = bus.o_z;
`ifdef SLL_SEQ_OVERFLOW_EN
        assign ovf_v[k] = bus.o_ovf;
`endif
        shift_left_logical_seq_32bit #(.STEP(1 << k)) dut (.clk(clk), .rst_n(rst_n), .io_bus(bus.slave));
    end

    function automatic bit in_range(input logic [31:0] y);
        int sy;
        sy = $signed(y);
        return sy >= 0 && sy <= 31;
    endfunction

    function automatic logic [31:0] m_z(input logic [31:0] x, input logic [31:0] y);
        return in_range(y) ? x << y : 32'd0;
    endfunction

    function automatic int m_sh(input logic [31:0] y, input int step);
        int n;
        n = in_range(y) ? int'(y) : 0;
        return (n + step - 1) / step;
    endfunction

    function automatic logic m_ovf(input logic [31:0] x, input logic [31:0] y);
        logic [63:0] wide;
        wide = {32'd0, x} << (in_range(y) ? y : 32'd0);
        return in_range(y) ? (wide[63:32] != 0) : (x != 0);
    endfunction

    task automatic chk(input string tag, input int step, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s step=%0d observed=%0h expected=%0h", tag, step, obs, exp);
        end
    endtask

    // start is presented at the current negedge; watch 40 cycles after the accepting edge
    task automatic go(input logic [31:0] x, input logic [31:0] y, input bit pulse, input string tag);
        int first [5];
        int ndone [5];
        int nbusy [5];
        bit zbad [5];
        for (int k = 0; k < 5; k++) begin
            first[k] = 0; ndone[k] = 0; nbusy[k] = 0; zbad[k] = 0;
        end
        start = 1'b1; x_in = x; y_in = y;
        for (int c = 1; c <= 40; c++) begin
            @(negedge clk);
            if (c == 1) begin
                start = 1'b0; x_in = $urandom; y_in = $urandom_range(31, 1);
            end
            if (pulse && c == 2) start = 1'b1;
            if (pulse && c == 3) start = 1'b0;
            for (int k = 0; k < 5; k++) begin
                if (first[k] == 0 && done_v[k] !== 1'b1 && z_v[k] !== prev_z[k]) zbad[k] = 1'b1;
                if (done_v[k] === 1'b1) begin
                    ndone[k]++;
                    if (first[k] == 0) first[k] = c;
                end
                if (busy_v[k] === 1'b1) nbusy[k]++;
            end
        end
        for (int k = 0; k < 5; k++) begin
            chk({tag, " latency"}, 1 << k, 32'(first[k]), 32'(m_sh(y, 1 << k) + 1));
            chk({tag, " done_count"}, 1 << k, 32'(ndone[k]), 32'd1);
            chk({tag, " busy_cycles"}, 1 << k, 32'(nbusy[k]), 32'(m_sh(y, 1 << k)));
            chk({tag, " z"}, 1 << k, z_v[k], m_z(x, y));
            chk({tag, " z_hold"}, 1 << k, 32'(zbad[k]), 32'd0);
`ifdef SLL_SEQ_OVERFLOW_EN
            chk({tag, " ovf"}, 1 << k, 32'(ovf_v[k]), 32'(m_ovf(x, y)));
`endif
            prev_z[k] = m_z(x, y);
        end
    endtask

    initial begin
        logic [31:0] x1;
        logic [31:0] rx;
        logic [31:0] ry;
        int stray;
        for (int k = 0; k < 5; k++) prev_z[k] = '0;
        #1;
        for (int k = 0; k < 5; k++) begin
            chk("reset busy", 1 << k, 32'(busy_v[k]), 32'd0);
            chk("reset done", 1 << k, 32'(done_v[k]), 32'd0);
            chk("reset z", 1 << k, z_v[k], 32'd0);
        end
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        go(32'h0000_0001, 32'd31, 1'b0, "one_by_31");
        go(32'h1234_5678, 32'd8, 1'b0, "y8");
        go(32'hDEAD_BEEF, 32'd0, 1'b0, "y0");
        go(32'hDEAD_BEEF, 32'd32, 1'b0, "y32");
        go(32'hDEAD_BEEF, 32'hFFFF_FFFF, 1'b0, "yneg1");
        go(32'h0000_0000, 32'd20, 1'b0, "x0");
        go(32'hA5A5_C3C3, 32'd31, 1'b1, "start_in_shift");
        x1 = 32'hCAFE_F00D;
        start = 1'b1; x_in = x1; y_in = 32'd0;
        @(negedge clk);
        for (int k = 0; k < 5; k++) begin
            chk("b2b first done", 1 << k, 32'(done_v[k]), 32'd1);
            chk("b2b first z", 1 << k, z_v[k], x1);
            prev_z[k] = x1;
        end
        go($urandom, 32'd13, 1'b0, "b2b second");
        start = 1'b1; x_in = $urandom; y_in = 32'd31;
        @(negedge clk);
        start = 1'b0;
        repeat (3) @(negedge clk);
        #2 rst_n = 1'b0;
        #1;
        stray = 0;
        for (int k = 0; k < 5; k++) begin
            chk("midreset busy", 1 << k, 32'(busy_v[k]), 32'd0);
            chk("midreset done", 1 << k, 32'(done_v[k]), 32'd0);
            chk("midreset z", 1 << k, z_v[k], 32'd0);
`ifdef SLL_SEQ_OVERFLOW_EN
            chk("midreset ovf", 1 << k, 32'(ovf_v[k]), 32'd0);
`endif
            prev_z[k] = '0;
        end
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 5; k++) if (done_v[k] !== 1'b0) stray++;
        end
        rst_n = 1'b1;
        repeat (3) begin
            @(negedge clk);
            for (int k = 0; k < 5; k++) if (done_v[k] !== 1'b0) stray++;
        end
        chk("midreset stray_done", 0, 32'(stray), 32'd0);
        go(32'h8000_0003, 32'd1, 1'b0, "after_reset");
        for (int i = 0; i < 30; i++) begin
            rx = (i % 7 == 0) ? 32'd0 : $urandom;
            ry = 32'(int'($urandom_range(44, 0)) - 4);
            go(rx, ry, 1'b0, "random");
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
